// File: rtl/led_mode_sequencer_pkg.sv
// Shared constants, state encoding and stage helpers for the LED mode sequencer.
package led_mode_sequencer_pkg;

  localparam int unsigned LED_W      = 18;
  localparam int unsigned NUM_STAGES = 3;

  localparam logic [1:0] STAGE_NONE = 2'd0;
  localparam logic [1:0] STAGE1     = 2'd1;
  localparam logic [1:0] STAGE2     = 2'd2;
  localparam logic [1:0] STAGE3     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST1   = 3'd1,
    S_ST2   = 3'd2,
    S_ST3   = 3'd3,
    S_GAP   = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  // Fixed rotation 1 -> 2 -> 3 -> 1.
  function automatic logic [1:0] next_stage_of(input logic [1:0] stage);
    return (stage == STAGE3) ? STAGE1 : 2'(stage + 2'd1);
  endfunction

  function automatic state_t stage_state(input logic [1:0] stage);
    case (stage)
      STAGE1:  return S_ST1;
      STAGE2:  return S_ST2;
      STAGE3:  return S_ST3;
      default: return S_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] state_stage(input state_t s);
    case (s)
      S_ST1:   return STAGE1;
      S_ST2:   return STAGE2;
      S_ST3:   return STAGE3;
      default: return STAGE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/over_edge_detect.sv
// Per-bit rising-edge detector on the stage completion flags.
module over_edge_detect
  import led_mode_sequencer_pkg::*;
#(
  parameter int unsigned W = NUM_STAGES
) (
  input  logic         clk,
  input  logic         rs,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (rs) prev <= '0;
    else    prev <= din;
  end

  assign rise_c = din & ~prev;

endmodule

// File: rtl/led_mode_sequencer.sv
// Cycles the three LED pattern stages, counting completions and guarding each pass with a watchdog.
module led_mode_sequencer
  import led_mode_sequencer_pkg::*;
#(
  parameter int unsigned REPEAT      = 2,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             run,
  input  logic             st1Over,
  input  logic             st2Over,
  input  logic             st3Over,
  input  logic [LED_W-1:0] st1Out,
  input  logic [LED_W-1:0] st2Out,
  input  logic [LED_W-1:0] st3Out,
  output logic             st1Begin,
  output logic             st2Begin,
  output logic             st3Begin,
  output logic             enabler,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             fault
);

  localparam int unsigned REP_W = $clog2(REPEAT) + 1;
  localparam int unsigned WD_W  = $clog2(WDOG_CYCLES) + 1;

  state_t            state, state_n;
  logic [REP_W-1:0]  rep_cnt, rep_cnt_n;
  logic [WD_W-1:0]   wdog, wdog_n;
  logic [1:0]        next_stage, next_stage_n;
  logic [NUM_STAGES-1:0] over_rise_c;
  logic              cur_done_c;

  logic [NUM_STAGES-1:0] begins_n;
  logic [LED_W-1:0]  led_n;
  logic [1:0]        mode_n;
  logic              fault_n;
  logic              enabler_n;

  over_edge_detect #(.W(NUM_STAGES)) u_over_edge (
    .clk    (clk),
    .rs     (rs),
    .din    ({st3Over, st2Over, st1Over}),
    .rise_c (over_rise_c)
  );

  // Only the active stage's completion edge counts.
  always_comb begin
    cur_done_c = 1'b0;
    case (state)
      S_ST1:   cur_done_c = over_rise_c[0];
      S_ST2:   cur_done_c = over_rise_c[1];
      S_ST3:   cur_done_c = over_rise_c[2];
      default: cur_done_c = 1'b0;
    endcase
  end

  // Next-state and counter logic; run=0 outranks everything below rs.
  always_comb begin
    state_n      = state;
    rep_cnt_n    = rep_cnt;
    wdog_n       = wdog;
    next_stage_n = next_stage;
    if (!run) begin
      state_n   = S_IDLE;
      rep_cnt_n = '0;
      wdog_n    = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n   = S_ST1;
          rep_cnt_n = '0;
          wdog_n    = '0;
        end
        S_ST1, S_ST2, S_ST3: begin
          if (cur_done_c) begin
            wdog_n = '0;
            if (rep_cnt == REP_W'(REPEAT - 1)) begin
              rep_cnt_n    = '0;
              next_stage_n = next_stage_of(state_stage(state));
              state_n      = S_GAP;
            end else begin
              rep_cnt_n = rep_cnt + REP_W'(1);
            end
          end else if (wdog == WD_W'(WDOG_CYCLES - 1)) begin
            state_n = S_FAULT;
          end else begin
            wdog_n = wdog + WD_W'(1);
          end
        end
        S_GAP: begin
          state_n = stage_state(next_stage);
          wdog_n  = '0;
        end
        S_FAULT: state_n = S_FAULT;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Output values derived from the state being entered, so outputs register alongside it.
  always_comb begin
    begins_n  = '0;
    led_n     = '0;
    mode_n    = state_stage(state_n);
    fault_n   = (state_n == S_FAULT);
    enabler_n = run && (state_n != S_FAULT);
    case (state_n)
      S_ST1: begin
        begins_n = 3'b001;
        led_n    = st1Out;
      end
      S_ST2: begin
        begins_n = 3'b010;
        led_n    = st2Out;
      end
      S_ST3: begin
        begins_n = 3'b100;
        led_n    = st3Out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      state      <= S_IDLE;
      rep_cnt    <= '0;
      wdog       <= '0;
      next_stage <= STAGE1;
    end else begin
      state      <= state_n;
      rep_cnt    <= rep_cnt_n;
      wdog       <= wdog_n;
      next_stage <= next_stage_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      st1Begin <= 1'b0;
      st2Begin <= 1'b0;
      st3Begin <= 1'b0;
      enabler  <= 1'b0;
      led      <= '0;
      mode     <= 2'd0;
      fault    <= 1'b0;
    end else begin
      st1Begin <= begins_n[0];
      st2Begin <= begins_n[1];
      st3Begin <= begins_n[2];
      enabler  <= enabler_n;
      led      <= led_n;
      mode     <= mode_n;
      fault    <= fault_n;
    end
  end

endmodule

// File: doc/led_mode_sequencer.md
# led_mode_sequencer

Top-level pattern controller for the 18-LED driver. Sits directly upstream of the three pattern stages (state-1, state-2 shift-window, state-3). It issues each stage's begin and enabler levels, counts completions via each stage's over flag, advances through the modes in a fixed cycle, and multiplexes the active stage's 18-bit pattern onto the LED bus. A watchdog flags a stage that never reports completion.

## Interface
Parameters:
- REPEAT, 2, complete passes of each stage before advancing (≥1)
- WDOG_CYCLES, 64, max clocks in one stage pass before fault (≥2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rs  in  1  reset, synchronous, active-high
- run  in  1  level; 1 = sequence runs, 0 = stop and return to idle
- st1Over / st2Over / st3Over  in  1 each  completion flags from stages 1–3
- st1Out / st2Out / st3Out  in  18 each  stage LED patterns
- st1Begin / st2Begin / st3Begin  out  1 each  registered stage-run levels
- enabler  out  1  registered; equals run while not in FAULT
- led  out  18  registered LED bus
- mode  out  2  registered; 0 idle/gap, 1–3 active stage
- fault  out  1  registered sticky watchdog flag

## Operation
- States: IDLE, ST1, ST2, ST3, GAP, FAULT.
- Reset values, all outputs: begins 0, enabler 0, led 18'b0, mode 0, fault 0. State IDLE, counters 0.
- IDLE: when run=1, go to ST1 next cycle. rep_cnt=0, wdog=0.
- STn (active stage n):
  - Drive stnBegin=1; all other begins 0.
  - led = stnOut, registered one cycle behind the input.
  - Detect a completion as a rising edge of stnOver, using a per-input previous-value register that updates every cycle.
  - On a completion edge:
    - If rep_cnt==REPEAT-1: rep_cnt←0 and go to GAP, with next_stage = n%3+1.
    - Otherwise: rep_cnt++.
  - wdog resets to 0 on each completion edge, otherwise increments. wdog==WDOG_CYCLES-1 without an edge → FAULT.
  - Over edges from non-active stages are ignored.
- GAP:
  - Exactly one cycle. All begins 0, led 0, mode 0.
  - Guarantees the finished stage sees begin=0 and returns to its reset pattern.
  - Then go to ST(next_stage). Sequence: 1→2→3→1…
- FAULT: begins 0, enabler 0, led 0, fault=1. Held until rs=1 or run=0; either returns to IDLE with fault cleared.
- run=0 in any state: next cycle IDLE, all begins 0, enabler 0, led 0, counters cleared. This has priority over completion and watchdog in the same cycle.
- Simultaneous completion edge and watchdog expiry in the same cycle: completion wins.
- rs overrides everything, including run.

## Timing
- All outputs are registered; the state register updates on the clk edge.
- run rises at edge k: state ST1 at edge k+1, so st1Begin=1 and enabler=1 from k+1.
- Active stage completion edge sampled at edge k: rep_cnt update at k+1, or GAP at k+1 and the next begin at k+2.
- led lags stnOut by one clock. During GAP and the first cycle of the next state, led shows 0 then the new stage's pattern.
- The stage's over flag may stay high for 1–2 cycles; edge detection guarantees exactly one count per pass.
- rs mid-operation: all outputs at reset values after the next edge.

## Structure
- Shared package:
  - State encoding constants (IDLE=0, ST1=1, ST2=2, ST3=3, GAP=4, FAULT=5).
  - LED_W=18.
  - Stage-index constants reused by the stage blocks and the top.
- One natural sub-module, `over_edge_detect`: per-bit rising-edge detector, 3 bits wide, clk/rs.
- rep_cnt width: clog2(REPEAT)+1. wdog width: clog2(WDOG_CYCLES)+1.

## Test plan
- Reset/idle: rs=1 for 2 cycles, run=0 → all begins 0, led=0, mode=0, fault=0. run=1 → st1Begin=1 and mode=1 one cycle later.
- Full cycle, REPEAT=2: pulse st1Over twice (2-cycle-wide high each) → GAP one cycle with all begins 0, then st2Begin=1. Continue through stage 3 back to stage 1; mode sequence 1,0,2,0,3,0,1.
- Over-width: hold st2Over high 2 cycles per pass → counted once per pass. Advance only after the 2nd pass, not the 1st.
- Mux: st1Out=18'h3, st2Out=18'h1C000 in ST1 → led=18'h3 one cycle later. Toggling a non-active over flag → no state change.
- Watchdog, WDOG_CYCLES=8: in ST2 never assert st2Over → fault=1, begins 0, enabler 0 after 8 cycles. Then run=0 → IDLE, fault=0.
- Priority: run=0 on the same cycle as the final completion edge → IDLE (not GAP). rs=1 mid-ST3 → reset values next edge.
